pc_fetch_unit: RTL and testbench

Instruction-fetch front end for the pipelined MIPS core. It owns the program counter, issues one word-aligned instruction read at a time to the memory subsystem, and tolerates any number of memory wait states. Fetched words go into a 2-entry buffer that feeds the decode stage through a valid/ready handshake. Taken branches and jumps redirect it and flush it.

---
 rtl/pc_fetch_unit.sv | 92 +++++++++
 tb/tb_pc_fetch_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, keeps one imem read in flight,
// and feeds decode from a 2-entry {instr, pc} buffer. Redirects flush it.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
);

  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  state_t            state, state_nx;
  logic [31:0]       pc, stale_addr;
  entry_t [1:0]      fifo;
  logic [1:0]        count;
  logic              pop, push, room;
  logic [1:0]        wr_idx;

  assign id_valid = (count != 2'd0);
  assign id_instr = fifo[0].instr;
  assign id_pc    = fifo[0].pc;
  assign id_pc4   = fifo[0].pc + 32'd4;

  assign pop  = id_valid & id_ready;
  assign room = (count < 2'd2) | pop;

  // WAIT/DRAIN keep req up until the ack; only FETCH may hold off.
  assign imem_req = ~rst & ((state == WAIT) | (state == DRAIN) |
                            ((state == FETCH) & room & ~redirect_valid));
  assign imem_addr = (state == DRAIN) ? stale_addr : pc;

  assign push = ~redirect_valid & imem_ack &
                (((state == FETCH) & imem_req) | (state == WAIT));
  assign wr_idx = count - {1'b0, pop};

  always_comb begin
    state_nx = state;
    case (state)
      FETCH: if (imem_req && !imem_ack) state_nx = WAIT;
      WAIT: begin
        if (imem_ack)            state_nx = FETCH;
        else if (redirect_valid) state_nx = DRAIN;
      end
      DRAIN: if (imem_ack) state_nx = FETCH;
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      stale_addr <= RESET_PC;
      count      <= 2'd0;
      fifo       <= {2{{32'h0000_0000, RESET_PC}}};
    end else begin
      state <= state_nx;
      // Remember the in-flight address so DRAIN can keep it stable after pc moves.
      if (state == WAIT && !imem_ack && redirect_valid) stale_addr <= pc;

      if (redirect_valid)  pc <= {redirect_pc[31:2], 2'b00};
      else if (push)       pc <= pc + 32'd4;

      if (redirect_valid) begin
        count <= 2'd0;
      end else begin
        if (pop) fifo[0] <= fifo[1];
        if (push) begin
          if (wr_idx == 2'd0) fifo[0] <= '{instr: imem_rdata, pc: pc};
          else                fifo[1] <= '{instr: imem_rdata, pc: pc};
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit: a memory model with random wait states,
// a queue-based model of the decode stream, and a decoupled monitor.
module tb_pc_fetch_unit;
  localparam logic [31:0] RP = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid, id_ready = 1'b0;
  logic [31:0] id_instr, id_pc, id_pc4;

  pc_fetch_unit #(.RESET_PC(RP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mpc = RP;
  bit          o_act = 0, o_dead = 0, prev_rst = 1;
  int          o_lat = 0;
  logic [31:0] o_addr = 32'h0;
  int          tests = 0, fails = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, play memory, then advance the model.
  task automatic cycle(input bit r, input bit rdy, input bit rdir,
                       input logic [31:0] tgt, input int maxlat, input bit late_ack);
    bit exp_req;
    @(negedge clk);
    rst = r; id_ready = rdy; redirect_valid = rdir; redirect_pc = tgt; imem_ack = 1'b0;
    #1;
    if (r) begin
      chk("req_in_rst", {31'b0, imem_req}, 32'd0);
      if (prev_rst) begin
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_id_pc", id_pc, RP);
        chk("rst_id_pc4", id_pc4, RP + 32'd4);
        chk("rst_id_instr", id_instr, 32'd0);
        chk("rst_imem_addr", imem_addr, RP);
      end
      imem_ack = late_ack;
      imem_rdata = $urandom;
    end else begin
      if (o_act) begin
        chk("req_hold", {31'b0, imem_req}, 32'd1);
        chk("addr_hold", imem_addr, o_addr);
      end else begin
        exp_req = !rdir && (q.size() < 2 || (rdy && q.size() != 0));
        chk("req", {31'b0, imem_req}, {31'b0, exp_req});
        if (imem_req) begin
          o_act = 1; o_dead = 0; o_addr = imem_addr;
          o_lat = $urandom_range(0, maxlat);
          chk("req_addr", imem_addr, mpc);
        end
      end
      if (o_act && o_lat == 0) imem_ack = 1'b1;
      else if (o_act) o_lat--;
      imem_rdata = imem_ack ? mem_word(o_addr) : $urandom;
    end
    #2;
    if (r) begin
      q.delete(); mpc = RP; o_act = 0;
    end else begin
      if (rdir) begin
        q.delete();
        mpc = {tgt[31:2], 2'b00};
        if (o_act) o_dead = 1;
      end else if (imem_ack && !o_dead) begin
        q.push_back('{pc: mpc, instr: mem_word(mpc)});
        mpc = mpc + 32'd4;
      end
      if (imem_ack) o_act = 0;
    end
    prev_rst = r;
  endtask

  // Monitor: compares the buffer head whenever decode takes it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        chk("id_valid", {31'b0, id_valid}, {31'b0, q.size() != 0});
        if (id_valid && id_ready && !redirect_valid && q.size() != 0) begin
          e = q.pop_front();
          chk("id_pc", id_pc, e.pc);
          chk("id_instr", id_instr, e.instr);
          chk("id_pc4", id_pc4, e.pc + 32'd4);
        end
      end
    end
  end

  task automatic wait_pending(output bit ok);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      cycle(0, 1, 0, 32'h0, 3, 0);
      if (o_act && o_lat > 0) ok = 1;
    end
    chk("pending_seen", {31'b0, ok}, 32'd1);
  endtask

  function automatic logic [31:0] rand_tgt();
    case ($urandom_range(0, 3))
      0: return 32'h0000_0102;
      1: return 32'hFFFF_FFF0 | $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit ok;
    int lat;
    repeat (3) cycle(1, 0, 0, 32'h0, 0, 0);
    // zero-wait stream across the 32-bit wrap
    repeat (24) cycle(0, 1, 0, 32'h0, 0, 0);
    // backpressure
    repeat (3) cycle(0, 1, 0, 32'h0, 0, 0);
    repeat (6) cycle(0, 0, 0, 32'h0, 0, 0);
    repeat (10) cycle(0, 1, 0, 32'h0, 0, 0);
    // redirect while a fetch is pending
    cycle(0, 1, 1, 32'h0000_0000, 0, 0);
    wait_pending(ok);
    cycle(0, 1, 1, 32'h0000_0102, 3, 0);
    repeat (12) cycle(0, 1, 0, 32'h0, 3, 0);
    // random traffic
    for (int blk = 0; blk < 20; blk++) begin
      lat = $urandom_range(0, 3);
      for (int i = 0; i < 100; i++)
        cycle(0, ($urandom % 4) != 0, ($urandom % 12) == 0, rand_tgt(), lat, 0);
    end
    // reset while waiting, with a late ack during reset
    wait_pending(ok);
    cycle(1, 1, 0, 32'h0, 0, 1);
    cycle(1, 1, 0, 32'h0, 0, 1);
    for (int i = 0; i < 300; i++)
      cycle(0, ($urandom % 3) != 0, ($urandom % 15) == 0, rand_tgt(), 2, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
